// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - imem, redirect and decode-side handshake bundle for the fetch unit
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_misaligned;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_rvalid,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc, if_pc4, if_misaligned,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_rvalid,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc, if_pc4, if_misaligned,
    output if_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, single-outstanding imem fetch, 2-entry FIFO to decode
// Optional IFU_MISALIGN_TRAP_EN: misaligned redirect targets become a trap entry instead of a fetch.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {BOOT, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, req_pc_q, target;
  logic        kill_q;
  logic [1:0]  count_q;
  logic [31:0] instr0_q, instr1_q, pc0_q, pc1_q;
  logic        mis0_q, mis1_q;
  logic        redirect, issue, data_push, push, pop, fetch_en, trap_push;
  logic [31:0] push_instr, push_pc;
  logic        push_mis;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fetch_off_q, trap_pend_q, redirect_mis;

  assign redirect_mis = bus.redirect_pc[1:0] != 2'b00;
  assign target       = bus.redirect_pc;
  assign fetch_en     = !fetch_off_q;
  assign trap_push    = trap_pend_q && !redirect;

  // Fetch stays parked after a misaligned redirect until the next redirect or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_off_q <= 1'b0;
      trap_pend_q <= 1'b0;
    end else if (redirect) begin
      fetch_off_q <= redirect_mis;
      trap_pend_q <= redirect_mis;
    end else begin
      trap_pend_q <= 1'b0;
    end
  end
`else
  assign target    = {bus.redirect_pc[31:2], 2'b00};
  assign fetch_en  = 1'b1;
  assign trap_push = 1'b0;
`endif

  assign redirect   = bus.redirect_valid;
  assign data_push  = (state_q == WAIT) && bus.imem_rvalid && !kill_q && !redirect;
  assign push       = data_push || trap_push;
  assign push_instr = trap_push ? NOP_INSTR : bus.imem_rdata;
  assign push_pc    = trap_push ? pc_q : req_pc_q;
  assign push_mis   = trap_push;
  assign pop        = (count_q != 2'd0) && bus.if_ready && !redirect;

  // Issuing only while count<2 reserves the slot the response will land in.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (count_q != 2'd2 && fetch_en && !redirect) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      kill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect) pc_q <= target;
      else if (issue) pc_q <= pc_q + 32'd4;
      if (issue) req_pc_q <= pc_q;
      // A redirect with a request in flight marks exactly that response as stale.
      if (state_q == WAIT) begin
        if (bus.imem_rvalid) kill_q <= 1'b0;
        else if (redirect) kill_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      instr0_q <= NOP_INSTR;
      pc0_q    <= RESET_PC;
      mis0_q   <= 1'b0;
      instr1_q <= NOP_INSTR;
      pc1_q    <= RESET_PC;
      mis1_q   <= 1'b0;
    end else if (redirect) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            instr0_q <= push_instr;
            pc0_q    <= push_pc;
            mis0_q   <= push_mis;
          end else begin
            instr1_q <= push_instr;
            pc1_q    <= push_pc;
            mis1_q   <= push_mis;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // Slot 0 is left untouched when draining the last entry so if_pc holds.
          if (count_q == 2'd2) begin
            instr0_q <= instr1_q;
            pc0_q    <= pc1_q;
            mis0_q   <= mis1_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            instr0_q <= push_instr;
            pc0_q    <= push_pc;
            mis0_q   <= push_mis;
          end else begin
            instr0_q <= instr1_q;
            pc0_q    <= pc1_q;
            mis0_q   <= mis1_q;
            instr1_q <= push_instr;
            pc1_q    <= push_pc;
            mis1_q   <= push_mis;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req      = issue;
  assign bus.imem_addr     = pc_q;
  assign bus.if_valid      = count_q != 2'd0;
  assign bus.if_instr      = (count_q != 2'd0) ? instr0_q : NOP_INSTR;
  assign bus.if_pc         = pc0_q;
  assign bus.if_pc4        = pc0_q + 32'd4;
  assign bus.if_misaligned = (count_q != 2'd0) && mis0_q;
endmodule
